// File: rtl/frame_sched_pkg.sv
// Shared mode/state codes for the frame-aligned engine scheduler.
// Mode codes double as engine selectors; 0 means raw camera bypass.
package frame_sched_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_COUNT  = 2'd1;
  localparam logic [1:0] MODE_COLOR  = 2'd2;
  localparam logic [1:0] MODE_DETECT = 2'd3;

  localparam int RUN_I    = 0;
  localparam int WAIT_I   = 1;
  localparam int DRAIN_I  = 2;
  localparam int SWITCH_I = 3;
  localparam int SETTLE_I = 4;

  typedef enum logic [4:0] {
    ST_RUN    = 5'b00001,
    ST_WAIT_VS = 5'b00010,
    ST_DRAIN  = 5'b00100,
    ST_SWITCH = 5'b01000,
    ST_SETTLE = 5'b10000
  } state_e;

  function automatic logic [2:0] mode2onehot(input logic [1:0] m);
    logic [2:0] oh;
    case (m)
      MODE_COUNT:  oh = 3'b001;
      MODE_COLOR:  oh = 3'b010;
      MODE_DETECT: oh = 3'b100;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic [1:0] req_decode(
    input logic cnt,
    input logic col,
    input logic det
  );
    logic [1:0] m;
    m = MODE_BYPASS;
    if (det) m = MODE_DETECT;
    if (col) m = MODE_COLOR;
    if (cnt) m = MODE_COUNT;
    return m;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// The pulse lands three clocks after the asynchronous input rises.
module sync_edge_det (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic sig,
  output logic rise
);

  logic [2:0] sh_q;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      sh_q <= '0;
      rise <= 1'b0;
    end else begin
      sh_q <= {sh_q[1:0], sig};
      rise <= sh_q[1] & ~sh_q[2];
    end
  end

endmodule

// File: rtl/frame_mode_sched.sv
// Turns level mode requests into frame-aligned one-hot engine enables,
// draining the old engine and masking output while the new one settles.
module frame_mode_sched
  import frame_sched_pkg::*;
#(
  parameter logic [19:0] DRAIN_TIMEOUT = 20'd500_000,
  parameter logic [1:0]  SETTLE_FRAMES = 2'd1
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       is_count_mode_i,
  input  logic       is_color_mode_i,
  input  logic       is_detect_mode_i,
  input  logic       frame_vsync_i,
  input  logic [2:0] engine_busy_i,
  output logic [2:0] engine_en_o,
  output logic [2:0] engine_clr_o,
  output logic       out_valid_mask_o,
  output logic       switch_busy_o,
  output logic       timeout_err_o
);

  logic        vs_rise;
  state_e      state_q, state_d;
  logic [1:0]  active_q, active_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  settle_q, settle_d;
  logic [19:0] drain_q, drain_d;
  logic        to_q, to_d;
  logic        err_d;
  logic [1:0]  req_mode;
  logic        drained;
  logic [2:0]  en_d, clr_d;
  logic        mask_d, busy_d;

  sync_edge_det u_vs_sync (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .sig       (frame_vsync_i),
    .rise      (vs_rise)
  );

  assign req_mode = req_decode(is_count_mode_i, is_color_mode_i,
                               is_detect_mode_i);
  // Bypass has no engine, so it is always drained.
  assign drained = ~|(engine_busy_i & mode2onehot(active_q));

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    settle_d = settle_q;
    drain_d  = drain_q;
    to_d     = to_q;
    err_d    = timeout_err_o;
    unique case (1'b1)
      state_q[RUN_I]: begin
        if (req_mode != active_q) begin
          pend_d  = req_mode;
          state_d = ST_WAIT_VS;
        end
      end
      state_q[WAIT_I]: begin
        pend_d = req_mode;
        if (req_mode == active_q) begin
          state_d = ST_RUN;
        end else if (vs_rise) begin
          state_d = ST_DRAIN;
          drain_d = '0;
          to_d    = 1'b0;
        end
      end
      state_q[DRAIN_I]: begin
        if (drained) begin
          state_d = ST_SWITCH;
        end else if (drain_q == DRAIN_TIMEOUT - 20'd1) begin
          state_d = ST_SWITCH;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else if (drain_q != '1) begin
          drain_d = drain_q + 20'd1;
        end
      end
      state_q[SWITCH_I]: begin
        active_d = pend_q;
        settle_d = '0;
        if (!to_q) err_d = 1'b0;
        state_d = (SETTLE_FRAMES == 2'd0) ? ST_RUN : ST_SETTLE;
      end
      state_q[SETTLE_I]: begin
        if (vs_rise) begin
          if (settle_q == SETTLE_FRAMES - 2'd1) state_d = ST_RUN;
          else settle_d = settle_q + 2'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Incoming engine is enabled together with its clear pulse.
  always_comb begin
    en_d   = 3'b000;
    clr_d  = 3'b000;
    mask_d = 1'b1;
    busy_d = ~state_q[RUN_I];
    unique case (1'b1)
      state_q[RUN_I],
      state_q[WAIT_I]: en_d = mode2onehot(active_q);
      state_q[DRAIN_I]: mask_d = 1'b0;
      state_q[SWITCH_I]: begin
        en_d   = mode2onehot(pend_q);
        clr_d  = mode2onehot(pend_q);
        mask_d = 1'b0;
      end
      state_q[SETTLE_I]: begin
        en_d   = mode2onehot(active_q);
        mask_d = 1'b0;
      end
      default: en_d = 3'b000;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q          <= ST_RUN;
      active_q         <= MODE_BYPASS;
      pend_q           <= MODE_BYPASS;
      settle_q         <= '0;
      drain_q          <= '0;
      to_q             <= 1'b0;
      timeout_err_o    <= 1'b0;
      engine_en_o      <= 3'b000;
      engine_clr_o     <= 3'b000;
      out_valid_mask_o <= 1'b1;
      switch_busy_o    <= 1'b0;
    end else begin
      state_q          <= state_d;
      active_q         <= active_d;
      pend_q           <= pend_d;
      settle_q         <= settle_d;
      drain_q          <= drain_d;
      to_q             <= to_d;
      timeout_err_o    <= err_d;
      engine_en_o      <= en_d;
      engine_clr_o     <= clr_d;
      out_valid_mask_o <= mask_d;
      switch_busy_o    <= busy_d;
    end
  end

endmodule

// File: tb/tb_frame_mode_sched.sv
// Randomised scoreboard bench for frame_mode_sched.
// Each switch sequence is checked when switch_busy_o falls.
module tb_frame_mode_sched;

  localparam logic [19:0] TO = 20'd50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       c = 1'b0, co = 1'b0, d = 1'b0;
  logic       vs = 1'b0;
  logic [2:0] busy = 3'b000;
  logic [2:0] en, clr;
  logic       mask, sw_busy, err;

  frame_mode_sched #(
    .DRAIN_TIMEOUT (TO),
    .SETTLE_FRAMES (2'd1)
  ) dut (
    .sys_clk_i        (clk),
    .sys_rst_i        (rst),
    .is_count_mode_i  (c),
    .is_color_mode_i  (co),
    .is_detect_mode_i (d),
    .frame_vsync_i    (vs),
    .engine_busy_i    (busy),
    .engine_en_o      (en),
    .engine_clr_o     (clr),
    .out_valid_mask_o (mask),
    .switch_busy_o    (sw_busy),
    .timeout_err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] en;
    logic [2:0] clr;
    int         clr_n;
    logic       mlow;
    logic       err;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         passes = 0;
  int         done_cnt = 0;
  logic [1:0] m_active = 2'd0;
  logic       m_err = 1'b0;
  logic [2:0] cur_req = 3'b000;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Requested mode: count beats color beats detect.
  function automatic logic [1:0] decode(logic [2:0] r);
    if (r[0]) return 2'd1;
    if (r[1]) return 2'd2;
    if (r[2]) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [2:0] oh(logic [1:0] m);
    logic [2:0] v;
    v = 3'b000;
    if (m != 2'd0) v[m - 2'd1] = 1'b1;
    return v;
  endfunction

  logic       prev_b = 1'b0;
  logic [2:0] clr_or = 3'b000;
  int         clr_n = 0;
  logic       mlow = 1'b0;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      prev_b = 1'b0;
      clr_or = 3'b000;
      clr_n  = 0;
      mlow   = 1'b0;
    end else begin
      if (sw_busy) begin
        clr_or |= clr;
        if (clr != 3'b000) clr_n++;
        if (!mask) mlow = 1'b1;
      end
      if (prev_b && !sw_busy) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got a switch end, expected none");
        end else begin
          e = q.pop_front();
          chk("en", int'(en), int'(e.en));
          chk("clr", int'(clr_or), int'(e.clr));
          chk("clr_len", clr_n, e.clr_n);
          chk("mask_low", int'(mlow), int'(e.mlow));
          chk("mask_end", int'(mask), 1);
          chk("err", int'(err), int'(e.err));
        end
        clr_or = 3'b000;
        clr_n  = 0;
        mlow   = 1'b0;
      end
      prev_b = sw_busy;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic [2:0] r);
    cur_req = r;
    c  = r[0];
    co = r[1];
    d  = r[2];
  endtask

  task automatic vs_pulse();
    cyc(int'($urandom_range(1, 4)));
    #2 vs = 1'b1;
    cyc(4);
    vs = 1'b0;
    cyc(5);
  endtask

  task automatic wait_done(int target, logic pulse_vs, int maxc);
    int n;
    n = 0;
    while (done_cnt < target && n < maxc) begin
      if (pulse_vs) begin
        vs_pulse();
        n += 12;
      end else begin
        cyc(1);
        n++;
      end
    end
    if (done_cnt < target) begin
      checks++;
      $display("FAIL wait_done: got %0d ends expected %0d", done_cnt, target);
    end
  endtask

  task automatic do_switch(logic [2:0] r, int hold, logic stuck,
                           logic [2:0] ob);
    logic [1:0] tgt, out_m;
    logic       to;
    int         base;
    tgt   = decode(r);
    out_m = m_active;
    base  = done_cnt;
    if (tgt == m_active) begin
      set_req(r);
      cyc(20);
      chk("no_switch", done_cnt - base, 0);
      return;
    end
    to = stuck && (out_m != 2'd0);
    q.push_back('{oh(tgt), oh(tgt), (tgt != 2'd0) ? 1 : 0, 1'b1, to});
    m_active = tgt;
    m_err    = to;
    busy = ob | oh(out_m);
    set_req(r);
    fork
      begin
        if (!stuck) begin
          cyc(hold);
          busy &= ~oh(out_m);
        end
      end
      wait_done(base + 1, 1'b1, 600);
    join
    busy = 3'b000;
    cyc(3);
  endtask

  task automatic do_cancel(logic [2:0] away);
    int         base;
    logic [2:0] back;
    back = cur_req;
    base = done_cnt;
    q.push_back('{oh(m_active), 3'b000, 0, 1'b0, m_err});
    set_req(away);
    cyc(5);
    set_req(back);
    wait_done(base + 1, 1'b0, 50);
    cyc(3);
  endtask

  task automatic prio_test();
    int base;
    base = done_cnt;
    q.push_back('{3'b001, 3'b001, 1, 1'b1, 1'b0});
    q.push_back('{3'b010, 3'b010, 1, 1'b1, 1'b0});
    set_req(3'b101);
    fork
      begin
        int k;
        k = 0;
        while (clr == 3'b000 && k < 800) begin
          @(negedge clk);
          k++;
        end
        set_req(3'b010);
      end
      wait_done(base + 2, 1'b1, 900);
    join
    m_active = 2'd2;
    m_err    = 1'b0;
    cyc(3);
  endtask

  task automatic reset_test();
    do_switch(3'b001, 0, 1'b0, 3'b000);
    busy = 3'b001;
    set_req(3'b100);
    vs_pulse();
    cyc(10);
    #3 rst = 1'b1;
    #1;
    chk("rst_en", int'(en), 0);
    chk("rst_clr", int'(clr), 0);
    chk("rst_mask", int'(mask), 1);
    chk("rst_busy", int'(sw_busy), 0);
    chk("rst_err", int'(err), 0);
    set_req(3'b000);
    busy = 3'b000;
    cyc(3);
    rst = 1'b0;
    m_active = 2'd0;
    m_err    = 1'b0;
    cyc(3);
  endtask

  initial begin
    #12;
    chk("init_en", int'(en), 0);
    chk("init_clr", int'(clr), 0);
    chk("init_mask", int'(mask), 1);
    chk("init_busy", int'(sw_busy), 0);
    chk("init_err", int'(err), 0);
    cyc(1);
    rst = 1'b0;
    cyc(3);

    do_switch(3'b001, 0, 1'b0, 3'b000);
    do_switch(3'b100, 0, 1'b1, 3'b000);
    do_cancel(3'b010);
    do_switch(3'b010, 30, 1'b0, 3'b000);
    prio_test();

    for (int i = 0; i < 12; i++) begin
      do_switch(3'($urandom_range(0, 7)), int'($urandom_range(0, 30)),
                ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    end

    reset_test();
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
